bsg_mem_fifo_1r1w_sync_ctrl: RTL

Ready/valid FIFO controller that drives an external 1r1w synchronous-read RAM (one-cycle read latency, same-address read/write collisions not allowed) and turns it into a streaming FIFO. It sits directly upstream of the RAM, owns its write and read ports, hides the read latency behind a 2-entry output buffer, and guarantees collision-free access. Total capacity is els_p+2 entries with full throughput of one entry per cycle in each direction.

---
 rtl/bsg_mem_fifo_1r1w_sync_ctrl_pkg.sv | 8 +
 rtl/bsg_mem_fifo_obuf.sv | 44 ++++
 rtl/bsg_mem_fifo_1r1w_sync_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/bsg_mem_fifo_1r1w_sync_ctrl_pkg.sv
// Shared helpers for the 1r1w sync-RAM FIFO controller.
package bsg_mem_fifo_1r1w_sync_ctrl_pkg;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_mem_fifo_obuf.sv
// Two-entry push/pop output buffer; slot0 always holds the oldest entry.
module bsg_mem_fifo_obuf #(
  parameter int width_p = -1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic [1:0]         cnt_o
);

  logic [width_p-1:0] slot0_r, slot1_r, slot0_n, slot1_n;
  logic [1:0]         cnt_r, cnt_n, kept;

  // Pop shifts first, then a push lands in the first free slot.
  always_comb begin
    slot0_n = pop_i ? slot1_r : slot0_r;
    slot1_n = slot1_r;
    kept    = cnt_r - 2'(pop_i);
    if (push_i) begin
      if (kept == 2'd0) slot0_n = data_i;
      else              slot1_n = data_i;
    end
    cnt_n = kept + 2'(push_i);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) cnt_r <= '0;
    else            cnt_r <= cnt_n;
  end

  always_ff @(posedge clk_i) begin
    slot0_r <= slot0_n;
    slot1_r <= slot1_n;
  end

  assign v_o    = (cnt_r != 2'd0);
  assign data_o = slot0_r;
  assign cnt_o  = cnt_r;

endmodule

// File: rtl/bsg_mem_fifo_1r1w_sync_ctrl.sv
// Streaming FIFO controller over an external 1r1w sync-read RAM; a 2-entry
// output buffer hides the read latency, giving els_p+2 total capacity.
module bsg_mem_fifo_1r1w_sync_ctrl
  import bsg_mem_fifo_1r1w_sync_ctrl_pkg::*;
#(
  parameter int width_p       = -1,
  parameter int els_p         = -1,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_w_v_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic                     mem_r_v_o,
  output logic [addr_width_lp-1:0] mem_r_addr_o,
  input  logic [width_p-1:0]       mem_r_data_i
);

  localparam int cnt_width_lp = safe_clog2(els_p + 1);
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0]  full_cnt_lp  = cnt_width_lp'(els_p);

  logic [addr_width_lp-1:0] wptr_r, rptr_r;
  logic [cnt_width_lp-1:0]  mem_cnt_r;
  logic                     rd_pend_r;

  logic               ob_v;
  logic [1:0]         ob_cnt;
  logic [width_p-1:0] ob_data, push_data;
  logic [2:0]         ob_after_deq, ob_after_rd;
  logic               enq, deq, bypass, mem_w, mem_r, push;

  always_comb begin
    ready_o      = reset_n_i & (mem_cnt_r != full_cnt_lp);
    deq          = yumi_i;
    enq          = v_i & ready_o;
    ob_after_deq = {1'b0, ob_cnt} - 3'(deq);
    ob_after_rd  = ob_after_deq + 3'(rd_pend_r);
    // Bypass only when nothing older is in RAM or in flight, preserving order.
    bypass       = enq & (mem_cnt_r == '0) & ~rd_pend_r & (ob_after_deq < 3'd2);
    mem_w        = enq & ~bypass;
    mem_r        = reset_n_i & (mem_cnt_r != '0) & (ob_after_rd < 3'd2);
    push         = bypass | rd_pend_r;
    push_data    = rd_pend_r ? mem_r_data_i : data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      mem_cnt_r <= '0;
      rd_pend_r <= 1'b0;
    end else begin
      if (mem_w) wptr_r <= (wptr_r == last_addr_lp) ? '0 : wptr_r + addr_width_lp'(1);
      if (mem_r) rptr_r <= (rptr_r == last_addr_lp) ? '0 : rptr_r + addr_width_lp'(1);
      mem_cnt_r <= mem_cnt_r + cnt_width_lp'(mem_w) - cnt_width_lp'(mem_r);
      rd_pend_r <= mem_r;
    end
  end

  bsg_mem_fifo_obuf #(.width_p(width_p)) obuf (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (push),
    .data_i   (push_data),
    .pop_i    (deq),
    .v_o      (ob_v),
    .data_o   (ob_data),
    .cnt_o    (ob_cnt)
  );

  assign v_o          = reset_n_i & ob_v;
  assign data_o       = ob_data;
  assign mem_w_v_o    = mem_w;
  assign mem_w_addr_o = wptr_r;
  assign mem_w_data_o = data_i;
  assign mem_r_v_o    = mem_r;
  assign mem_r_addr_o = rptr_r;

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
    else $error("yumi_i asserted while v_o is low");

endmodule
